adc_conversion_sequencer: RTL

Sequences an ADC0804-style 8-bit parallel ADC for the voltmeter datapath. On a programmable sample tick it:
- pulses CS_n/WR_n to start a conversion;
- waits for the converter's INTR_n;
- strobes CS_n/RD_n to read the result.

It presents each raw sample and a boxcar average of 2^AVG_LOG2 samples to the BCD/digit display path. It runs on the on-chip oscillator clock, upstream of the value-to-digits conversion.

---
 rtl/adc_conversion_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/adc_conversion_sequencer.sv
// Periodic start/wait/read sequencer for an ADC0804-style converter.
// Publishes each raw 8-bit code plus a boxcar average of 2^AVG_LOG2 codes.
module adc_conversion_sequencer #(
  parameter int unsigned SAMPLE_PERIOD   = 2080,
  parameter int unsigned WR_PULSE_CYCLES = 4,
  parameter int unsigned RD_CYCLES       = 4,
  parameter int unsigned CONV_TIMEOUT    = 255,
  parameter int unsigned AVG_LOG2        = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       clear_err,
  input  logic       intr_n,
  input  logic [7:0] adc_data,
  output logic       CS_n,
  output logic       WR_n,
  output logic       RD_n,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic [7:0] avg_sample,
  output logic       avg_valid,
  output logic       busy,
  output logic       timeout_err,
  output logic       overrun_err
);
  localparam int unsigned ACC_W = 8 + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam logic [15:0] PER_LAST = 16'(SAMPLE_PERIOD - 1);
  localparam logic [15:0] TMO_LAST = 16'(CONV_TIMEOUT - 1);
  localparam logic [3:0]  WR_LAST  = 4'(WR_PULSE_CYCLES - 1);
  localparam logic [3:0]  RD_LAST  = 4'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] AVG_N = CNT_W'(1 << AVG_LOG2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_READ, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             intr_meta_q, intr_s_q;
  logic [15:0]      per_cnt_q, per_cnt_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic [3:0]       phase_q, phase_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0] n_q, n_d, n_inc;
  logic [7:0]       sample_q, sample_d, avg_q, avg_d;
  logic             sample_valid_q, sample_valid_d, avg_valid_q, avg_valid_d;
  logic             cs_n_q, wr_n_q, rd_n_q;
  logic             tmo_q, tmo_d, ovr_q, ovr_d;
  logic             tick, timeout_hit;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    phase_d        = phase_q;
    acc_d          = acc_q;
    n_d            = n_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    avg_d          = avg_q;
    avg_valid_d    = 1'b0;
    timeout_hit    = 1'b0;
    tick           = enable && (per_cnt_q == PER_LAST);
    per_cnt_d      = (!enable || tick) ? 16'd0 : per_cnt_q + 16'd1;
    sum            = acc_q + ACC_W'(adc_data);
    n_inc          = n_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (!enable) begin
          acc_d = '0;
          n_d   = '0;
        end
        if (tick) begin
          state_d = S_START;
          phase_d = 4'd0;
        end
      end
      S_START: begin
        if (phase_q == WR_LAST) begin
          state_d    = S_WAIT;
          wait_cnt_d = 16'd0;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      // End-of-conversion is checked before the timeout so a coincident INTR wins.
      S_WAIT: begin
        if (!intr_s_q) begin
          state_d = S_READ;
          phase_d = 4'd0;
        end else if (wait_cnt_q == TMO_LAST) begin
          state_d     = S_IDLE;
          timeout_hit = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      // Capture and average on the last READ edge so the results appear in DONE.
      S_READ: begin
        if (phase_q == RD_LAST) begin
          state_d        = S_DONE;
          sample_d       = adc_data;
          sample_valid_d = 1'b1;
          if (n_inc == AVG_N) begin
            avg_d       = 8'(sum >> AVG_LOG2);
            avg_valid_d = 1'b1;
            acc_d       = '0;
            n_d         = '0;
          end else begin
            acc_d = sum;
            n_d   = n_inc;
          end
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    tmo_d = timeout_hit | (tmo_q & ~clear_err);
    ovr_d = (tick && (state_q != S_IDLE)) | (ovr_q & ~clear_err);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q        <= S_IDLE;
      intr_meta_q    <= 1'b1;
      intr_s_q       <= 1'b1;
      per_cnt_q      <= 16'd0;
      wait_cnt_q     <= 16'd0;
      phase_q        <= 4'd0;
      acc_q          <= '0;
      n_q            <= '0;
      sample_q       <= 8'd0;
      sample_valid_q <= 1'b0;
      avg_q          <= 8'd0;
      avg_valid_q    <= 1'b0;
      cs_n_q         <= 1'b1;
      wr_n_q         <= 1'b1;
      rd_n_q         <= 1'b1;
      tmo_q          <= 1'b0;
      ovr_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      intr_meta_q    <= intr_n;
      intr_s_q       <= intr_meta_q;
      per_cnt_q      <= per_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      phase_q        <= phase_d;
      acc_q          <= acc_d;
      n_q            <= n_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      avg_q          <= avg_d;
      avg_valid_q    <= avg_valid_d;
      cs_n_q         <= !((state_d == S_START) || (state_d == S_READ));
      wr_n_q         <= (state_d != S_START);
      rd_n_q         <= (state_d != S_READ);
      tmo_q          <= tmo_d;
      ovr_q          <= ovr_d;
    end
  end

  assign CS_n         = cs_n_q;
  assign WR_n         = wr_n_q;
  assign RD_n         = rd_n_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign avg_sample   = avg_q;
  assign avg_valid    = avg_valid_q;
  assign busy         = (state_q != S_IDLE);
  assign timeout_err  = tmo_q;
  assign overrun_err  = ovr_q;
endmodule
